// File: rtl/robo_controle.sv
// Left-hand wall-following controller: turns head/left/barreira readings from the map stage
// into one move, rotate or 3-cycle clean command per decision, stopping on step budget or trap.
module robo_controle #(
    parameter int MAX_PASSOS = 1000
) (
    input  logic        clockc1,
    input  logic        reset,
    input  logic        inicia,
    input  logic [3:0]  head,
    input  logic [3:0]  left,
    input  logic        barreira,
    output logic [2:0]  acao,
    output logic [2:0]  orientacao,
    output logic        parado,
    output logic        preso,
    output logic [15:0] passos,
    output logic [15:0] limpezas
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_DECIDE, S_ACT, S_CLEAN, S_STOP
    } estado_t;

    localparam logic [15:0] LP_MAX    = 16'(MAX_PASSOS);
    localparam logic [2:0]  LP_LIMPAR = 3'b101;

    estado_t     r_estado, w_prox;
    logic [2:0]  r_acao, w_acao;
    logic [2:0]  r_ori, w_ori;
    logic        r_parado, w_parado;
    logic        r_preso, w_preso;
    logic [15:0] r_passos, w_passos;
    logic [15:0] r_limp, w_limp;
    logic        r_virou, w_virou;
    logic [2:0]  r_giros, w_giros;
    logic [1:0]  r_cnt, w_cnt;

    function automatic logic [2:0] gira_esq(input logic [2:0] o);
        case (o)
            3'b001:  gira_esq = 3'b010;
            3'b010:  gira_esq = 3'b100;
            3'b100:  gira_esq = 3'b011;
            default: gira_esq = 3'b001;
        endcase
    endfunction

    function automatic logic [2:0] gira_dir(input logic [2:0] o);
        case (o)
            3'b001:  gira_dir = 3'b011;
            3'b011:  gira_dir = 3'b100;
            3'b100:  gira_dir = 3'b010;
            default: gira_dir = 3'b001;
        endcase
    endfunction

    function automatic logic [15:0] inc_sat(input logic [15:0] v);
        inc_sat = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clockc1) begin
        if (reset) begin
            r_estado <= S_IDLE;
            r_acao   <= 3'b000;
            r_ori    <= 3'b001;
            r_parado <= 1'b0;
            r_preso  <= 1'b0;
            r_passos <= 16'd0;
            r_limp   <= 16'd0;
            r_virou  <= 1'b0;
            r_giros  <= 3'd0;
            r_cnt    <= 2'd0;
        end else begin
            r_estado <= w_prox;
            r_acao   <= w_acao;
            r_ori    <= w_ori;
            r_parado <= w_parado;
            r_preso  <= w_preso;
            r_passos <= w_passos;
            r_limp   <= w_limp;
            r_virou  <= w_virou;
            r_giros  <= w_giros;
            r_cnt    <= w_cnt;
        end
    end

    // Stop conditions outrank every movement rule.
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            S_IDLE:   if (inicia) w_prox = S_SETTLE;
            S_SETTLE: w_prox = S_DECIDE;
            S_DECIDE: begin
                if (r_giros == 3'd4 || r_passos == LP_MAX) w_prox = S_STOP;
                else if (barreira)                         w_prox = S_CLEAN;
                else                                       w_prox = S_ACT;
            end
            S_ACT:    w_prox = S_SETTLE;
            S_CLEAN:  if (r_cnt == 2'd2) w_prox = S_SETTLE;
            S_STOP:   w_prox = S_STOP;
            default:  w_prox = S_IDLE;
        endcase
    end

    always_comb begin
        w_acao   = 3'b000;
        w_ori    = r_ori;
        w_parado = r_parado;
        w_preso  = r_preso;
        w_passos = r_passos;
        w_limp   = r_limp;
        w_virou  = r_virou;
        w_giros  = r_giros;
        w_cnt    = r_cnt;
        case (r_estado)
            S_DECIDE: begin
                if (r_giros == 3'd4) begin
                    w_parado = 1'b1;
                    w_preso  = 1'b1;
                end else if (r_passos == LP_MAX) begin
                    w_parado = 1'b1;
                end else if (barreira) begin
                    w_acao = LP_LIMPAR;
                    w_limp = inc_sat(r_limp);
                    w_cnt  = 2'd0;
                end else if (left == 4'd0 && !r_virou) begin
                    w_ori   = gira_esq(r_ori);
                    w_virou = 1'b1;
                    w_giros = r_giros + 3'd1;
                end else if (head == 4'd0) begin
                    w_acao   = r_ori;
                    w_virou  = 1'b0;
                    w_giros  = 3'd0;
                    w_passos = inc_sat(r_passos);
                end else begin
                    w_ori   = gira_dir(r_ori);
                    w_virou = 1'b0;
                    w_giros = r_giros + 3'd1;
                end
            end
            // Burst length: cnt 0,1,2 each hold the clean command for one cycle.
            S_CLEAN: begin
                if (r_cnt != 2'd2) begin
                    w_acao = LP_LIMPAR;
                    w_cnt  = r_cnt + 2'd1;
                end
            end
            default: ;
        endcase
    end

    assign acao       = r_acao;
    assign orientacao = r_ori;
    assign parado     = r_parado;
    assign preso      = r_preso;
    assign passos     = r_passos;
    assign limpezas   = r_limp;
endmodule

// File: tb/tb_robo_controle.sv
// Directed bench for robo_controle: corridor, cleaning, left turn, trap, step budget, reset mid-clean.
module tb_robo_controle;
    logic        clk;
    logic        reset, inicia, barreira;
    logic [3:0]  head, left;
    logic [2:0]  acao, orientacao;
    logic        parado, preso;
    logic [15:0] passos, limpezas;

    logic        reset3, inicia3, barreira3;
    logic [3:0]  head3, left3;
    logic [2:0]  acao3, orientacao3;
    logic        parado3, preso3;
    logic [15:0] passos3, limpezas3;

    int n_chk  = 0;
    int n_pass = 0;

    robo_controle u_dut (
        .clockc1(clk), .reset(reset), .inicia(inicia), .head(head), .left(left),
        .barreira(barreira), .acao(acao), .orientacao(orientacao), .parado(parado),
        .preso(preso), .passos(passos), .limpezas(limpezas)
    );

    robo_controle #(.MAX_PASSOS(3)) u_dut3 (
        .clockc1(clk), .reset(reset3), .inicia(inicia3), .head(head3), .left(left3),
        .barreira(barreira3), .acao(acao3), .orientacao(orientacao3), .parado(parado3),
        .preso(preso3), .passos(passos3), .limpezas(limpezas3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        int moves;
        logic [2:0] seq [4];
        seq[0] = 3'b011; seq[1] = 3'b100; seq[2] = 3'b010; seq[3] = 3'b001;

        reset = 1'b1; inicia = 1'b0; head = 4'd0; left = 4'd1; barreira = 1'b0;
        reset3 = 1'b1; inicia3 = 1'b0; head3 = 4'd0; left3 = 4'd1; barreira3 = 1'b0;
        tick();
        reset = 1'b0; reset3 = 1'b0;
        chk("rst_acao", 16'(acao), 16'h0);
        chk("rst_ori", 16'(orientacao), 16'h1);
        chk("rst_parado", 16'(parado), 16'h0);
        chk("rst_preso", 16'(preso), 16'h0);
        chk("rst_passos", passos, 16'h0);
        chk("rst_limp", limpezas, 16'h0);

        // inicia on the same edge as reset: reset wins, robot stays idle
        reset = 1'b1; inicia = 1'b1;
        tick();
        reset = 1'b0; inicia = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_wins_acao", 16'(acao), 16'h0);
        end
        chk("rst_wins_passos", passos, 16'h0);

        // free corridor facing north
        inicia = 1'b1;
        tick();
        inicia = 1'b0;
        tick();
        tick();
        chk("fwd_acao_1", 16'(acao), 16'h1);
        chk("fwd_passos_1", passos, 16'd1);
        for (int k = 2; k <= 3; k++) begin
            tick();
            chk("fwd_gap_a", 16'(acao), 16'h0);
            tick();
            chk("fwd_gap_b", 16'(acao), 16'h0);
            tick();
            chk("fwd_acao", 16'(acao), 16'h1);
            chk("fwd_passos", passos, 16'(k));
        end

        // debris ahead: three clean cycles then idle
        barreira = 1'b1;
        tick();
        tick();
        tick();
        barreira = 1'b0;
        chk("cln_acao_1", 16'(acao), 16'h5);
        chk("cln_limp", limpezas, 16'd1);
        chk("cln_ori", 16'(orientacao), 16'h1);
        tick();
        chk("cln_acao_2", 16'(acao), 16'h5);
        tick();
        chk("cln_acao_3", 16'(acao), 16'h5);
        tick();
        chk("cln_end_acao", 16'(acao), 16'h0);
        chk("cln_end_limp", limpezas, 16'd1);
        chk("cln_end_passos", passos, 16'd3);
        chk("cln_end_ori", 16'(orientacao), 16'h1);

        // left opening: turn west, then move west instead of turning again
        left = 4'd0; head = 4'd0;
        tick();
        tick();
        chk("lft_ori", 16'(orientacao), 16'h2);
        chk("lft_acao", 16'(acao), 16'h0);
        tick();
        tick();
        tick();
        chk("lft_move_acao", 16'(acao), 16'h2);
        chk("lft_move_passos", passos, 16'd4);
        left = 4'd1;

        // boxed in: E, S, W, N then trapped stop
        reset = 1'b1;
        tick();
        reset = 1'b0;
        head = 4'd1; left = 4'd3;
        inicia = 1'b1;
        tick();
        inicia = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tick();
            chk("trap_ori", 16'(orientacao), 16'(seq[i]));
            chk("trap_acao", 16'(acao), 16'h0);
            tick();
        end
        tick();
        tick();
        chk("trap_parado", 16'(parado), 16'h1);
        chk("trap_preso", 16'(preso), 16'h1);
        chk("trap_passos", passos, 16'd0);
        chk("trap_acao_stop", 16'(acao), 16'h0);
        inicia = 1'b1; head = 4'd0;
        for (int i = 0; i < 5; i++) tick();
        inicia = 1'b0;
        chk("stop_absorb_parado", 16'(parado), 16'h1);
        chk("stop_absorb_acao", 16'(acao), 16'h0);

        // reset during the second clean cycle abandons the burst
        reset = 1'b1;
        tick();
        reset = 1'b0;
        head = 4'd0; left = 4'd1; barreira = 1'b1;
        inicia = 1'b1;
        tick();
        inicia = 1'b0;
        tick();
        tick();
        chk("mid_cln_first", 16'(acao), 16'h5);
        tick();
        chk("mid_cln_second", 16'(acao), 16'h5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_acao", 16'(acao), 16'h0);
        chk("mid_rst_limp", limpezas, 16'd0);
        chk("mid_rst_passos", passos, 16'd0);
        chk("mid_rst_ori", 16'(orientacao), 16'h1);
        chk("mid_rst_parado", 16'(parado), 16'h0);
        for (int i = 0; i < 4; i++) tick();
        chk("mid_rst_idle_acao", 16'(acao), 16'h0);
        chk("mid_rst_idle_limp", limpezas, 16'd0);
        barreira = 1'b0;

        // step budget of 3 on a free corridor
        inicia3 = 1'b1;
        tick();
        inicia3 = 1'b0;
        moves = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (acao3 == 3'b001) moves++;
        end
        chk("max_moves", 16'(moves), 16'd3);
        chk("max_parado", 16'(parado3), 16'h1);
        chk("max_preso", 16'(preso3), 16'h0);
        chk("max_passos", passos3, 16'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/robo_controle.md
# robo_controle

- Left-hand wall-following controller for the pipe-cleaner robot.
- Sits directly upstream of the map/sensor stage: it consumes that stage's `head`, `left` and `barreira` readings and produces the `acao`/`orientacao` commands that stage executes.
- Each decision is one of: move forward one cell, rotate in place, or run a 3-clock cleaning burst on the debris cell ahead.
- It stops after a configured step budget or when it is boxed in.

## Interface

- `MAX_PASSOS`, default 1000: forward moves allowed before a normal stop; must fit 16 bits.
- `clockc1` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `inicia` in 1: start request, sampled in IDLE only.
- `head` in [0:3]: cell ahead; 0 = free, 1 = wall. Debris is reported as 0 plus `barreira`.
- `left` in [0:3]: cell to the left; 0 = free, nonzero = blocked.
- `barreira` in 1: debris ahead.
- `acao` out [0:2]: 000 idle, 001 N, 010 W, 011 E, 100 S, 101 clean.
- `orientacao` out [0:2]: 001 N, 010 W, 011 E, 100 S.
- `parado` out 1: high in STOP.
- `preso` out 1: high in STOP when the cause is a trap (4 consecutive rotations).
- `passos` out [0:15]: forward moves executed.
- `limpezas` out [0:15]: cleaning bursts executed.

## Operation

- All outputs are registered.
- States: IDLE, SETTLE, DECIDE, ACT, CLEAN, STOP.
- Rotation tables:
  - Left: N→W, W→S, S→E, E→N.
  - Right: N→E, E→S, S→W, W→N.
- Internal state: `virou_esq` flag (1 bit) and `giros` counter (3 bits).
- IDLE: `acao`=000. Stays in IDLE until `inicia`=1, then goes to SETTLE.
- SETTLE: one cycle with `acao`=000 so the map stage refreshes its readings. Then DECIDE.
- DECIDE: `acao`=000. Samples inputs at the closing edge and applies the first matching rule:
  1. `barreira`=1 → CLEAN with `acao`=101 and orientation unchanged; `limpezas`+1.
  2. `left`==0 and `virou_esq`=0 → `orientacao`=left(o), `acao` stays 000, `virou_esq`=1, `giros`+1 → ACT.
  3. `head`==0 → `acao`=code of o (numerically equal to `orientacao`), `virou_esq`=0, `giros`=0, `passos`+1 → ACT.
  4. Otherwise → `orientacao`=right(o), `virou_esq`=0, `giros`+1 → ACT.
- Stop conditions, checked in DECIDE, take priority over all rules above:
  - `giros`==4 → STOP with `preso`=1.
  - `passos`==`MAX_PASSOS` → STOP with `preso`=0.
- ACT: the command is presented for exactly one cycle. `acao` returns to 000 at the closing edge → SETTLE.
- CLEAN: `acao`=101 for exactly 3 cycles, counted by a 2-bit counter. Then `acao`=000 → SETTLE.
  - The debris is re-evaluated after SETTLE; a still-dirty cell triggers another burst.
- STOP: `acao`=000 and `parado`=1. Absorbing; only `reset` leaves it.
- Counters saturate at 16'hFFFF.

## Timing

- Reset values: state IDLE, `acao`=000, `orientacao`=001 (robot starts facing north), `parado`=0, `preso`=0, `passos`=0, `limpezas`=0, `virou_esq`=0, `giros`=0.
- Reset mid-operation: all of the above are restored at the next edge, including mid-CLEAN. A partial burst is abandoned, not completed.
- Latency:
  - Move or rotate: 3 cycles per decision (DECIDE → ACT → SETTLE).
  - Clean: 5 cycles (DECIDE → 3×CLEAN → SETTLE).
- Input contract: the map stage registers `head`/`left`/`barreira` at the same edge that samples `acao`/`orientacao`. SETTLE guarantees the readings DECIDE sees reflect the previous command.
- `inicia` asserted on the same edge as `reset`: reset wins.
- `inicia` is ignored outside IDLE.
- An orientation change becomes visible on `orientacao` at the first ACT cycle and holds until the next decision.

## Test plan

- Reset, then `inicia`=1 with `head`=0, `left`=1, `barreira`=0 held → `acao`=001 on one ACT cycle every 3 cycles; `passos` increments by 1 each time.
- `barreira`=1 at DECIDE → `acao`=101 for exactly 3 cycles, then 000; `limpezas`=1; `orientacao` unchanged.
- Facing N with `left`=0 → `orientacao`=010 and `acao`=000. At the next DECIDE with `left`=0 and `head`=0, the robot moves (`acao`=010) instead of turning left again.
- `head`=1, `left`=1 held constantly → orientation sequence E, S, W, N; then `parado`=1, `preso`=1, `passos`=0.
- `MAX_PASSOS`=3 with a free corridor → exactly 3 forward commands, then `parado`=1, `preso`=0.
- `reset` asserted during the second CLEAN cycle → next cycle `acao`=000, state IDLE, all counters 0.
